// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares the single-port main RAM between the M65C02 core and one secondary
//   DMA requester. The CPU keeps the RAM for the microcycles in which it is
//   doing a RAM access. DMA is given the MC=4 slot, or any cycle in which the
//   CPU is not touching RAM. Sits between the address decoder / CPU and the RAM.
//
// Ports
//   clk_25mhz    in   system clock
//   system_rst   in   synchronous reset, active-high
//   cpu_addr     in   CPU address
//   cpu_ram_cs   in   address decoder RAM select
//   cpu_io_op    in   M65C02 IO_Op (00 none, 01 write, 10 read, 11 fetch)
//   cpu_mc       in   M65C02 microcycle state (4 -> 6 -> 7 -> 5)
//   cpu_dout     in   CPU write data
//   dma_req      in   DMA request; dma_addr/dma_we/dma_wdata stable while high
//   dma_we       in   DMA direction, 1 = write
//   dma_addr     in   DMA address
//   dma_wdata    in   DMA write data
//   dma_ack      out  one-clock pulse in the cycle the DMA access goes to RAM
//   dma_rdata    out  DMA read data, held until the next DMA read completes
//   dma_rvalid   out  one-clock pulse, dma_rdata carries fresh read data
//   dma_busy     out  request latched, not yet acked
//   ram_addr     out  RAM address
//   ram_we       out  RAM write enable
//   ram_din      out  RAM write data
//   ram_dout     in   RAM read data (one-clock synchronous read)
//
// State table
//   ST_IDLE | no request held; a high dma_req is latched into the q registers
//   ST_PEND | request held; issued to RAM in the first cycle the CPU leaves free

module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_25mhz,
  input  logic                  system_rst,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_ram_cs,
  input  logic [1:0]            cpu_io_op,
  input  logic [2:0]            cpu_mc,
  input  logic [DATA_WIDTH-1:0] cpu_dout,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_ack,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  dma_rvalid,
  output logic                  dma_busy,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam logic [1:0] IO_NONE  = 2'b00;
  localparam logic [1:0] IO_WRITE = 2'b01;
  localparam logic [2:0] MC_SLOT  = 3'b100;
  localparam logic [2:0] MC_WRITE = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q;

  logic cpu_active;
  logic cpu_owns;
  logic slot_free;
  logic issue;
  logic cpu_we;
  logic latch_req;

  // Any MC value other than 4 (including out-of-sequence ones) belongs to the
  // CPU while it has a RAM access in flight, so its read and write timing is
  // never disturbed.
  assign cpu_active = cpu_ram_cs && (cpu_io_op != IO_NONE);
  assign cpu_owns   = cpu_active && (cpu_mc != MC_SLOT);
  assign slot_free  = !cpu_owns;

  // CPU write strobe only in MC=7; MC=7 always implies cpu_owns, so this can
  // never collide with a DMA issue cycle.
  assign cpu_we = cpu_ram_cs && (cpu_io_op == IO_WRITE) && (cpu_mc == MC_WRITE);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_25mhz) begin
    if (system_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (dma_req) begin
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        // A request still held high after the ack is treated as a new one and
        // latched from IDLE on the following clock.
        if (slot_free) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    latch_req = 1'b0;
    issue     = 1'b0;
    dma_busy  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        latch_req = dma_req;
      end
      ST_PEND: begin
        dma_busy = 1'b1;
        issue    = slot_free;
      end
      default: begin
        latch_req = 1'b0;
      end
    endcase
  end

  assign dma_ack = issue;

  // RAM port mux: the latched DMA access only in its issue cycle, otherwise
  // the CPU address/data with the CPU write rule.
  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_dout;
    ram_we   = cpu_we;
    if (issue) begin
      ram_addr = addr_q;
      ram_din  = wdata_q;
      ram_we   = we_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Request capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_25mhz) begin
    if (system_rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (latch_req) begin
      addr_q  <= dma_addr;
      we_q    <= dma_we;
      wdata_q <= dma_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return
  // ---------------------------------------------------------------------------
  // The RAM registers the issued address on the issue edge, so ram_dout holds
  // the DMA byte during the following cycle. That cycle passes ram_dout
  // straight through with rvalid; rdata_q keeps it for later cycles.
  always_ff @(posedge clk_25mhz) begin
    if (system_rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= issue && !we_q;
      if (rvalid_q) begin
        rdata_q <= ram_dout;
      end
    end
  end

  assign dma_rvalid = rvalid_q;
  assign dma_rdata  = rvalid_q ? ram_dout : rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural 32KB synchronous RAM, a CPU
// microcycle driver and a read-data scoreboard.

module tb_ram_port_arbiter;

  localparam int AW = 15;
  localparam int DW = 8;

  logic          clk_25mhz = 1'b0;
  logic          system_rst;
  logic [AW-1:0] cpu_addr;
  logic          cpu_ram_cs;
  logic [1:0]    cpu_io_op;
  logic [2:0]    cpu_mc;
  logic [DW-1:0] cpu_dout;
  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;
  logic          dma_rvalid;
  logic          dma_busy;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  always #5 clk_25mhz = ~clk_25mhz;

  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_25mhz  (clk_25mhz),
    .system_rst (system_rst),
    .cpu_addr   (cpu_addr),
    .cpu_ram_cs (cpu_ram_cs),
    .cpu_io_op  (cpu_io_op),
    .cpu_mc     (cpu_mc),
    .cpu_dout   (cpu_dout),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_ack    (dma_ack),
    .dma_rdata  (dma_rdata),
    .dma_rvalid (dma_rvalid),
    .dma_busy   (dma_busy),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] ref_mem [0:32767];
  logic [7:0] ram_mem [0:32767];
  bit         ram_ready;
  bit         cpu_loop;

  function automatic logic [7:0] pat(input logic [14:0] a);
    return a[7:0] ^ {1'b0, a[14:8]};
  endfunction

  // Behavioural RAM, read-first, contents seeded on the first clock edge.
  always @(posedge clk_25mhz) begin
    if (!ram_ready) begin
      for (int i = 0; i < 32768; i++) ram_mem[i] <= pat(15'(i));
      ram_ready <= 1'b1;
    end else begin
      if (ram_we) ram_mem[ram_addr] <= ram_din;
      ram_dout <= ram_mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] next_mc(input logic [2:0] mc);
    case (mc)
      3'd4:    return 3'd6;
      3'd6:    return 3'd7;
      3'd7:    return 3'd5;
      default: return 3'd4;
    endcase
  endfunction

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic cyc();
    @(negedge clk_25mhz);
    if (cpu_loop) cpu_mc = next_mc(cpu_mc);
  endtask

  task automatic step();
    cyc();
    #1;
  endtask

  task automatic wait_mc(input logic [2:0] target);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (cpu_mc != target && n < 8);
    if (cpu_mc != target) chk("wait_mc", cpu_mc, target);
  endtask

  // Scoreboard: every DMA read return is matched against the queued byte.
  always @(negedge clk_25mhz) begin
    #2;
    if (dma_rvalid === 1'b1) begin
      if (exp_q.size() == 0) chk("rvalid_unexpected", dma_rvalid, 1'b0);
      else chk("rdata", dma_rdata, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] t4_addr [4];
    int acks, bad_mc, win_err, win_cnt, rd_err, n;

    cpu_loop   = 1'b0;
    cpu_mc     = 3'd4;
    cpu_addr   = '0;
    cpu_ram_cs = 1'b0;
    cpu_io_op  = 2'b00;
    cpu_dout   = '0;
    dma_req    = 1'b0;
    dma_we     = 1'b0;
    dma_addr   = '0;
    dma_wdata  = '0;
    system_rst = 1'b1;
    for (int i = 0; i < 32768; i++) ref_mem[i] = pat(15'(i));

    // Reset state
    repeat (4) step();
    chk("rst_busy", dma_busy, 1'b0);
    chk("rst_ack", dma_ack, 1'b0);
    chk("rst_rvalid", dma_rvalid, 1'b0);
    chk("rst_rdata", dma_rdata, 8'h00);
    cyc();
    system_rst = 1'b0;
    cpu_loop   = 1'b1;
    cpu_ram_cs = 1'b1;
    #1;

    // 1: DMA write with the CPU idle
    cyc();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 15'h1234; dma_wdata = 8'h5A;
    #1;
    chk("t1_ack_early", dma_ack, 1'b0);
    chk("t1_busy_early", dma_busy, 1'b0);
    cyc();
    dma_req = 1'b0;
    #1;
    chk("t1_ack", dma_ack, 1'b1);
    chk("t1_busy", dma_busy, 1'b1);
    chk("t1_we", ram_we, 1'b1);
    chk("t1_addr", ram_addr, 15'h1234);
    chk("t1_din", ram_din, 8'h5A);
    ref_mem[15'h1234] = 8'h5A;
    step();
    chk("t1_ack_after", dma_ack, 1'b0);
    chk("t1_busy_after", dma_busy, 1'b0);
    chk("t1_no_rvalid", dma_rvalid, 1'b0);

    // 2: DMA read while the CPU fetches from RAM, raised at MC=6
    cyc();
    cpu_io_op = 2'b11; cpu_addr = 15'h0100;
    #1;
    wait_mc(3'd6);
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 15'h1234;
    exp_q.push_back(ref_mem[15'h1234]);
    #1;
    chk("t2_ack_mc6", dma_ack, 1'b0);
    cyc();
    dma_req = 1'b0;
    #1;
    chk("t2_ack_mc7", dma_ack, 1'b0);
    chk("t2_busy_mc7", dma_busy, 1'b1);
    step();
    chk("t2_ack_mc5", dma_ack, 1'b0);
    chk("t2_cpu_rd", ram_dout, ref_mem[15'h0100]);
    step();
    chk("t2_ack_mc4", dma_ack, 1'b1);
    chk("t2_addr_mc4", ram_addr, 15'h1234);
    chk("t2_we_mc4", ram_we, 1'b0);
    step();
    chk("t2_rvalid", dma_rvalid, 1'b1);
    chk("t2_rdata", dma_rdata, 8'h5A);
    step();
    chk("t2_rvalid_pulse", dma_rvalid, 1'b0);
    chk("t2_rdata_hold", dma_rdata, 8'h5A);
    step();
    chk("t2_cpu_rd_next", ram_dout, ref_mem[15'h0100]);

    // 3: CPU write at MC=7 with a DMA write pending
    wait_mc(3'd6);
    cpu_io_op = 2'b01; cpu_addr = 15'h0010; cpu_dout = 8'hA5;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 15'h0020; dma_wdata = 8'h3C;
    #1;
    chk("t3_we_mc6", ram_we, 1'b0);
    cyc();
    dma_req = 1'b0;
    #1;
    chk("t3_we_mc7", ram_we, 1'b1);
    chk("t3_addr_mc7", ram_addr, 15'h0010);
    chk("t3_din_mc7", ram_din, 8'hA5);
    chk("t3_ack_mc7", dma_ack, 1'b0);
    step();
    chk("t3_we_mc5", ram_we, 1'b0);
    chk("t3_ack_mc5", dma_ack, 1'b0);
    step();
    chk("t3_ack_mc4", dma_ack, 1'b1);
    chk("t3_we_mc4", ram_we, 1'b1);
    chk("t3_addr_mc4", ram_addr, 15'h0020);
    chk("t3_din_mc4", ram_din, 8'h3C);
    ref_mem[15'h0010] = 8'hA5;
    ref_mem[15'h0020] = 8'h3C;
    cyc();
    cpu_io_op = 2'b11;
    #1;

    // 4: CPU off RAM, req held high for 4 back-to-back reads
    t4_addr[0] = 15'h0010; t4_addr[1] = 15'h0020;
    t4_addr[2] = 15'h1234; t4_addr[3] = 15'h7FFF;
    cyc();
    cpu_ram_cs = 1'b0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = t4_addr[0];
    exp_q.push_back(ref_mem[t4_addr[0]]);
    #1;
    chk("t4_ack_first", dma_ack, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k < 3) begin
        dma_addr = t4_addr[k+1];
        exp_q.push_back(ref_mem[t4_addr[k+1]]);
      end else begin
        dma_req = 1'b0;
      end
      #1;
      chk("t4_ack", dma_ack, 1'b1);
      chk("t4_addr", ram_addr, t4_addr[k]);
      if (k < 3) begin
        step();
        chk("t4_gap", dma_ack, 1'b0);
      end
    end
    step();
    step();

    // 5: reset while a request waits in PEND
    cyc();
    cpu_ram_cs = 1'b1;
    #1;
    wait_mc(3'd6);
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 15'h0020;
    #1;
    cyc();
    dma_req = 1'b0; system_rst = 1'b1;
    #1;
    chk("t5_busy_pre", dma_busy, 1'b1);
    cyc();
    system_rst = 1'b0;
    #1;
    chk("t5_busy", dma_busy, 1'b0);
    chk("t5_rvalid", dma_rvalid, 1'b0);
    chk("t5_rdata", dma_rdata, 8'h00);
    step();
    chk("t5_no_ack", dma_ack, 1'b0);
    chk("t5_busy_mc4", dma_busy, 1'b0);
    cyc();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 15'h0010;
    exp_q.push_back(ref_mem[15'h0010]);
    #1;
    cyc();
    dma_req = 1'b0;
    #1;
    n = 0;
    while (dma_ack !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    chk("t5_ack_served", dma_ack, 1'b1);
    step();
    step();

    // 6: CPU RAM loop with req held high for 400 clocks
    cpu_io_op = 2'b11;
    wait_mc(3'd6);
    cpu_io_op = 2'b10;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 15'h1234;
    #1;
    acks = 0; bad_mc = 0; win_err = 0; win_cnt = 0; rd_err = 0;
    for (int i = 0; i < 400; i++) begin
      if (i != 0) begin
        cyc();
        if (cpu_mc == 3'd4) cpu_addr = cpu_addr + 15'd37;
        #1;
      end
      if (dma_ack === 1'b1) begin
        acks++;
        win_cnt++;
        if (cpu_mc != 3'd4) bad_mc++;
        exp_q.push_back(ref_mem[dma_addr]);
      end
      if (cpu_mc == 3'd5 && i > 3) begin
        if (win_cnt != 1) win_err++;
        win_cnt = 0;
        if (ram_dout !== ref_mem[cpu_addr]) rd_err++;
      end
    end
    cyc();
    dma_req = 1'b0;
    #1;
    chk("t6_acks", acks, 100);
    chk("t6_ack_not_mc4", bad_mc, 0);
    chk("t6_window", win_err, 0);
    chk("t6_cpu_rd", rd_err, 0);
    repeat (3) step();
    chk("t6_ack_stop", dma_busy, 1'b0);
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
